// File: rtl/core_if.sv
// ---------------------------------------------------------------------------
// core_if : instruction-fetch stage
//
// Holds the program counter, issues word fetches to instruction memory over a
// req/ready request channel, collects in-order responses on an rvalid channel
// into a small prefetch FIFO, and presents the head entry (instruction plus
// its address) to decode. Later stages can stall the head (hold) or redirect
// the fetch stream (jump), which flushes the FIFO and discards every response
// still outstanding at that moment.
//
// Parameters
//   RESET_PC   : PC loaded on reset
//   FIFO_DEPTH : prefetch entries (power of two, >= 2); also bounds the sum of
//                in-flight requests and buffered entries
//   NOP_INST   : instruction presented when no entry is valid
//
// Ports
//   clk            : clock
//   rst            : synchronous active-high reset
//   hold_in        : downstream stall, keep the head entry
//   jump_en_in     : redirect request
//   jump_addr_in   : redirect target, bits [1:0] ignored
//   mem_req_out    : fetch request valid
//   mem_addr_out   : fetch word address
//   mem_ready_in   : memory accepts the request this cycle
//   mem_rvalid_in  : response valid (in request order)
//   mem_rdata_in   : response instruction word
//   inst_valid_out : head entry valid
//   inst_out       : head instruction, NOP_INST when empty
//   inst_addr_out  : head instruction address, 0 when empty
// ---------------------------------------------------------------------------
module core_if #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_in,
  input  logic        jump_en_in,
  input  logic [31:0] jump_addr_in,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_ready_in,
  input  logic        mem_rvalid_in,
  input  logic [31:0] mem_rdata_in,
  output logic        inst_valid_out,
  output logic [31:0] inst_out,
  output logic [31:0] inst_addr_out
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  // Counters must be able to hold the value FIFO_DEPTH itself.
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(FIFO_DEPTH);
  localparam logic [CW:0]   DepthWide = (CW + 1)'(FIFO_DEPTH);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [31:0]   r_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;

  logic [31:0] r_fifo_addr [FIFO_DEPTH];
  logic [31:0] r_fifo_inst [FIFO_DEPTH];

  // Next-state values
  logic [31:0]   w_pc_d;
  logic [31:0]   w_resp_pc_d;
  logic [CW-1:0] w_inflight_d;
  logic [CW-1:0] w_drop_d;
  logic [CW-1:0] w_count_d;
  logic [AW-1:0] w_rd_ptr_d;
  logic [AW-1:0] w_wr_ptr_d;

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  logic [31:0]   w_jump_target;
  logic          w_unused_jump_bits;
  logic [CW:0]   w_occupancy;
  logic          w_credit_ok;
  logic          w_accept;
  logic          w_resp;
  logic          w_resp_keep;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_accept_inc;
  logic [CW-1:0] w_resp_dec;
  logic [CW-1:0] w_push_inc;
  logic [CW-1:0] w_pop_dec;

  assign w_jump_target      = {jump_addr_in[31:2], 2'b00};
  assign w_unused_jump_bits = ^jump_addr_in[1:0];

  // Every accepted request owns a FIFO slot until it is popped or dropped, so
  // a response can never find the FIFO full.
  assign w_occupancy = {1'b0, r_inflight} + {1'b0, r_count};
  assign w_credit_ok = (w_occupancy < DepthWide);

  assign mem_req_out  = !rst && !jump_en_in && w_credit_ok;
  assign mem_addr_out = r_pc;
  assign w_accept     = mem_req_out && mem_ready_in;

  // A response with nothing outstanding is stale (e.g. issued before a reset).
  assign w_resp      = mem_rvalid_in && (r_inflight != '0);
  assign w_resp_keep = w_resp && (r_drop == '0);
  // A response landing in a jump cycle belongs to the old stream.
  assign w_push      = w_resp_keep && !jump_en_in;
  assign w_pop       = inst_valid_out && !hold_in && !jump_en_in;

  assign w_accept_inc = {{(CW-1){1'b0}}, w_accept};
  assign w_resp_dec   = {{(CW-1){1'b0}}, w_resp};
  assign w_push_inc   = {{(CW-1){1'b0}}, w_push};
  assign w_pop_dec    = {{(CW-1){1'b0}}, w_pop};

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_pc_d       = r_pc;
    w_resp_pc_d  = r_resp_pc;
    w_inflight_d = r_inflight + w_accept_inc - w_resp_dec;
    w_drop_d     = r_drop;
    w_count_d    = r_count;
    w_rd_ptr_d   = r_rd_ptr;
    w_wr_ptr_d   = r_wr_ptr;

    if (jump_en_in) begin
      // No request is issued in a jump cycle, so w_inflight_d already holds
      // exactly the requests still outstanding; all of them become stale.
      w_pc_d      = w_jump_target;
      w_resp_pc_d = w_jump_target;
      w_drop_d    = w_inflight_d;
      w_count_d   = '0;
      w_rd_ptr_d  = '0;
      w_wr_ptr_d  = '0;
    end else begin
      if (w_accept) begin
        w_pc_d = r_pc + 32'd4;
      end
      if (w_resp && (r_drop != '0)) begin
        w_drop_d = r_drop - {{(CW-1){1'b0}}, 1'b1};
      end
      if (w_push) begin
        w_resp_pc_d = r_resp_pc + 32'd4;
        w_wr_ptr_d  = r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (w_pop) begin
        w_rd_ptr_d = r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      w_count_d = r_count + w_push_inc - w_pop_dec;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_pc       <= w_pc_d;
      r_resp_pc  <= w_resp_pc_d;
      r_inflight <= w_inflight_d;
      r_drop     <= w_drop_d;
      r_count    <= w_count_d;
      r_rd_ptr   <= w_rd_ptr_d;
      r_wr_ptr   <= w_wr_ptr_d;
    end
  end

  // Storage is not reset; only entries below r_count are ever observed.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_fifo_addr[r_wr_ptr] <= r_resp_pc;
      r_fifo_inst[r_wr_ptr] <= mem_rdata_in;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: head entry straight from registers, no response bypass
  // -------------------------------------------------------------------------
  always_comb begin
    inst_valid_out = (r_count != '0);
    inst_out       = NOP_INST;
    inst_addr_out  = 32'h0000_0000;
    if (inst_valid_out) begin
      inst_out      = r_fifo_inst[r_rd_ptr];
      inst_addr_out = r_fifo_addr[r_rd_ptr];
    end
  end

  // -------------------------------------------------------------------------
  // Invariants
  // -------------------------------------------------------------------------
`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(w_resp_keep && !jump_en_in && (r_count == DepthC)))
        else $error("core_if: response pushed into a full prefetch FIFO");
      assert (w_occupancy <= DepthWide)
        else $error("core_if: in-flight plus buffered exceeds FIFO_DEPTH");
      assert (r_drop <= r_inflight)
        else $error("core_if: drop count exceeds in-flight count");
      assert (r_pc[1:0] == 2'b00)
        else $error("core_if: fetch address not word aligned");
    end
  end
`endif

endmodule
